// File: rtl/sram_access_ctrl_if.sv
// rtl/sram_access_ctrl_if.sv - request/response handshake bundle for sram_access_ctrl
interface sram_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [14:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/sram_access_ctrl.sv
// rtl/sram_access_ctrl.sv - element-wide request sequencer for a reconfigurable 1k x 32 SRAM macro
module sram_access_ctrl #(
    parameter int RD_LAT     = 1,
    parameter int RESP_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cfg_valid_i,
    input  logic [2:0]  cfg_conf_i,
    output logic        cfg_ready_o,
    output logic [2:0]  conf_o,
    sram_access_ctrl_if.slave bus,
    output logic        sram_en_o,
    output logic        sram_we_o,
    output logic [9:0]  sram_addr_o,
    output logic [31:0] sram_wmask_o,
    output logic [31:0] sram_din_o,
    input  logic [31:0] sram_dout_i,
    output logic        busy_o
);
    localparam int PW = $clog2(RESP_DEPTH);
    localparam int CW = $clog2(RESP_DEPTH + 1);

    typedef enum logic [0:0] {IDLE, CFG_DRAIN} state_t;

    function automatic logic [4:0] lane_shift(input logic [2:0] kk, input logic [4:0] ln);
        return 5'(ln << (3'd5 - kk));
    endfunction

    function automatic logic [31:0] elem_mask(input logic [2:0] kk);
        return 32'hFFFF_FFFF >> (6'd32 - (6'd32 >> kk));
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  conf_q, conf_d;
    logic [2:0]  k;
    logic [4:0]  lane, idx_msk;
    logic [9:0]  word;
    logic [31:0] wmask, din_rep;
    logic        req_ready, accept, credit, any_inflight;
    int          occ;

    logic        en_q, we_q;
    logic [9:0]  addr_q;
    logic [31:0] wmask_q, din_q;
    logic [4:0]  lane_q;
    logic [2:0]  k_q;
    logic [RD_LAT-1:0]      pv_q;
    logic [RD_LAT-1:0][4:0] pl_q;
    logic [RD_LAT-1:0][2:0] pk_q;

    logic [31:0]   mem_q [RESP_DEPTH];
    logic [PW-1:0] wp_q, rp_q;
    logic [CW-1:0] cnt_q;
    logic          push, pop;
    logic [31:0]   push_data;

    // Codes 110/111 behave as 32k x 1.
    always_comb begin
        k       = (conf_q > 3'd5) ? 3'd5 : conf_q;
        lane    = bus.req_addr[4:0] & 5'((6'd1 << k) - 6'd1);
        word    = 10'(bus.req_addr >> k);
        wmask   = elem_mask(k) << lane_shift(k, lane);
        idx_msk = 5'((6'd32 >> k) - 6'd1);
        din_rep = '0;
        for (int i = 0; i < 32; i++) begin
            din_rep[i] = bus.req_wdata[5'(i) & idx_msk];
        end
    end

    // Credits cover every read that will land in the FIFO, including ones still on the macro.
    always_comb begin
        occ = 32'(cnt_q) + 32'(en_q & ~we_q);
        for (int i = 0; i < RD_LAT; i++) begin
            occ = occ + 32'(pv_q[i]);
        end
        credit       = occ < RESP_DEPTH;
        any_inflight = en_q | (|pv_q);
    end

    always_comb begin
        state_d     = state_q;
        conf_d      = conf_q;
        cfg_ready_o = 1'b0;
        req_ready   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_valid_i) begin
                    state_d = CFG_DRAIN;
                end else begin
                    req_ready = bus.req_we | credit;
                end
            end
            CFG_DRAIN: begin
                if (!any_inflight) begin
                    conf_d      = cfg_conf_i;
                    cfg_ready_o = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept    = bus.req_valid & req_ready;
    assign push      = pv_q[RD_LAT-1];
    assign pop       = (cnt_q != '0) & bus.rsp_ready;
    assign push_data = (sram_dout_i >> lane_shift(pk_q[RD_LAT-1], pl_q[RD_LAT-1]))
                     & elem_mask(pk_q[RD_LAT-1]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            conf_q  <= '0;
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wmask_q <= '0;
            din_q   <= '0;
            lane_q  <= '0;
            k_q     <= '0;
            pv_q    <= '0;
            pl_q    <= '0;
            pk_q    <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            conf_q  <= conf_d;
            en_q    <= accept;
            we_q    <= accept & bus.req_we;
            addr_q  <= accept ? word : '0;
            wmask_q <= (accept & bus.req_we) ? wmask : '0;
            din_q   <= (accept & bus.req_we) ? din_rep : '0;
            lane_q  <= lane;
            k_q     <= k;
            pv_q[0] <= en_q & ~we_q;
            pl_q[0] <= lane_q;
            pk_q[0] <= k_q;
            for (int i = 1; i < RD_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                pl_q[i] <= pl_q[i-1];
                pk_q[i] <= pk_q[i-1];
            end
            if (push) begin
                mem_q[wp_q] <= push_data;
                wp_q        <= wp_q + PW'(1);
            end
            if (pop) begin
                rp_q <= rp_q + PW'(1);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + CW'(1);
            end else if (pop && !push) begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = (cnt_q != '0);
    assign bus.rsp_data  = (cnt_q != '0) ? mem_q[rp_q] : '0;
    assign conf_o        = conf_q;
    assign sram_en_o     = en_q;
    assign sram_we_o     = we_q;
    assign sram_addr_o   = addr_q;
    assign sram_wmask_o  = wmask_q;
    assign sram_din_o    = din_q;
    assign busy_o        = any_inflight | (cnt_q != '0) | (state_q == CFG_DRAIN) | cfg_valid_i;
endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb/tb_sram_access_ctrl.sv - directed vector bench for sram_access_ctrl with a behavioural SRAM
module tb_sram_access_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid, cfg_ready;
    logic [2:0]  cfg_conf, conf;
    logic        sram_en, sram_we, busy;
    logic [9:0]  sram_addr;
    logic [31:0] sram_wmask, sram_din, sram_dout;
    logic [31:0] mem [1024];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [2:0]  cur_conf;

    sram_access_ctrl_if bus();

    sram_access_ctrl #(.RD_LAT(1), .RESP_DEPTH(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .cfg_valid_i(cfg_valid), .cfg_conf_i(cfg_conf), .cfg_ready_o(cfg_ready), .conf_o(conf),
        .bus(bus),
        .sram_en_o(sram_en), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
        .sram_wmask_o(sram_wmask), .sram_din_o(sram_din), .sram_dout_i(sram_dout),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    // One-cycle-latency macro; garbage on dout whenever no read was issued.
    always @(posedge clk) begin
        sram_dout <= 32'hDEAD_BEEF;
        if (rst) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
        end else if (sram_en) begin
            if (sram_we) mem[sram_addr] <= (mem[sram_addr] & ~sram_wmask) | (sram_din & sram_wmask);
            else         sram_dout <= mem[sram_addr];
        end
    end

    typedef struct {
        logic [2:0]  conf;
        logic        we;
        logic [14:0] addr;
        logic [31:0] wdata;
        logic [9:0]  e_addr;
        logic [31:0] e_wmask;
        logic [31:0] e_din;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vt [17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_conf(input logic [2:0] c);
        logic got;
        got = 1'b0;
        cfg_valid = 1'b1;
        cfg_conf  = c;
        for (int n = 0; n < 20 && !got; n++) begin
            #1;
            if (cfg_ready) got = 1'b1;
            step();
        end
        cfg_valid = 1'b0;
        chk("cfg_ready_seen", 32'(got), 32'd1);
        chk("conf_loaded", 32'(conf), 32'(c));
        cur_conf = c;
    endtask

    task automatic do_req(input logic we, input logic [14:0] a, input logic [31:0] d);
        logic got;
        got = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        for (int n = 0; n < 20 && !got; n++) begin
            #1;
            if (bus.req_ready) got = 1'b1;
            step();
        end
        bus.req_valid = 1'b0;
        chk("req_accepted", 32'(got), 32'd1);
    endtask

    task automatic wait_rsp(output logic [31:0] data, output int lat);
        logic got;
        got  = 1'b0;
        data = '0;
        lat  = -1;
        bus.rsp_ready = 1'b1;
        for (int n = 0; n < 20 && !got; n++) begin
            if (bus.rsp_valid) begin
                got  = 1'b1;
                data = bus.rsp_data;
                lat  = n;
            end
            step();
        end
        chk("rsp_arrived", 32'(got), 32'd1);
    endtask

    task automatic rd_check(input string nm, input logic [14:0] a, input logic [31:0] exp);
        logic [31:0] d;
        int          lat;
        do_req(1'b0, a, '0);
        wait_rsp(d, lat);
        chk(nm, d, exp);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] got_d [4];
        int          lat, nr, acc;
        logic        rdy, got;

        vt[0]  = '{3'd0, 1'b1, 15'h0005, 32'hA5A5_1234, 10'd5, 32'hFFFF_FFFF, 32'hA5A5_1234, 32'h0};
        vt[1]  = '{3'd0, 1'b0, 15'h0005, 32'h0,         10'd5, 32'h0,         32'h0,         32'hA5A5_1234};
        vt[2]  = '{3'd2, 1'b1, 15'h0013, 32'h0000_00CD, 10'd4, 32'hFF00_0000, 32'hCDCD_CDCD, 32'h0};
        vt[3]  = '{3'd2, 1'b0, 15'h0013, 32'h0,         10'd4, 32'h0,         32'h0,         32'h0000_00CD};
        vt[4]  = '{3'd2, 1'b0, 15'h0010, 32'h0,         10'd4, 32'h0,         32'h0,         32'h0};
        vt[5]  = '{3'd1, 1'b1, 15'h000B, 32'hFFFF_BEEF, 10'd5, 32'hFFFF_0000, 32'hBEEF_BEEF, 32'h0};
        vt[6]  = '{3'd1, 1'b0, 15'h000A, 32'h0,         10'd5, 32'h0,         32'h0,         32'h0000_1234};
        vt[7]  = '{3'd1, 1'b0, 15'h000B, 32'h0,         10'd5, 32'h0,         32'h0,         32'h0000_BEEF};
        vt[8]  = '{3'd3, 1'b0, 15'h002A, 32'h0,         10'd5, 32'h0,         32'h0,         32'h0000_0002};
        vt[9]  = '{3'd3, 1'b0, 15'h002F, 32'h0,         10'd5, 32'h0,         32'h0,         32'h0000_000B};
        vt[10] = '{3'd0, 1'b0, 15'h0405, 32'h0,         10'd5, 32'h0,         32'h0,         32'hBEEF_1234};
        vt[11] = '{3'd4, 1'b1, 15'h0017, 32'h0000_0007, 10'd1, 32'h0000_C000, 32'hFFFF_FFFF, 32'h0};
        vt[12] = '{3'd4, 1'b0, 15'h0017, 32'h0,         10'd1, 32'h0,         32'h0,         32'h0000_0003};
        vt[13] = '{3'd4, 1'b0, 15'h0016, 32'h0,         10'd1, 32'h0,         32'h0,         32'h0};
        vt[14] = '{3'd6, 1'b1, 15'h0045, 32'h0000_0003, 10'd2, 32'h0000_0020, 32'hFFFF_FFFF, 32'h0};
        vt[15] = '{3'd7, 1'b0, 15'h0045, 32'h0,         10'd2, 32'h0,         32'h0,         32'h0000_0001};
        vt[16] = '{3'd7, 1'b0, 15'h0044, 32'h0,         10'd2, 32'h0,         32'h0,         32'h0};

        rst = 1'b1;
        cfg_valid = 1'b0;
        cfg_conf = '0;
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;
        cur_conf = 3'd0;
        repeat (3) step();
        rst = 1'b0;
        chk("rst_conf", 32'(conf), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_sram_en", 32'(sram_en), 32'd0);
        chk("rst_sram_wmask", sram_wmask, 32'd0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 17; i++) begin
            if (vt[i].conf != cur_conf) set_conf(vt[i].conf);
            do_req(vt[i].we, vt[i].addr, vt[i].wdata);
            chk($sformatf("v%0d_en", i), 32'(sram_en), 32'd1);
            chk($sformatf("v%0d_we", i), 32'(sram_we), 32'(vt[i].we));
            chk($sformatf("v%0d_addr", i), 32'(sram_addr), 32'(vt[i].e_addr));
            chk($sformatf("v%0d_wmask", i), sram_wmask, vt[i].e_wmask);
            chk($sformatf("v%0d_din", i), sram_din, vt[i].e_din);
            if (!vt[i].we) begin
                wait_rsp(d, lat);
                chk($sformatf("v%0d_rdata", i), d, vt[i].e_rdata);
                chk($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
            end
        end

        // 32k x 1: back-to-back bit writes into word 0
        set_conf(3'd5);
        nr = 0;
        for (int i = 0; i < 32; i++) begin
            bus.req_valid = 1'b1;
            bus.req_we    = 1'b1;
            bus.req_addr  = 15'(i);
            bus.req_wdata = (i % 2 == 0) ? 32'h1 : 32'h0;
            #1;
            if (!bus.req_ready) nr++;
            step();
        end
        bus.req_valid = 1'b0;
        chk("b2b_write_stalls", 32'(nr), 32'd0);
        chk("b2b_last_en", 32'(sram_en), 32'd1);
        step();
        chk("idle_en", 32'(sram_en), 32'd0);
        chk("idle_wmask", sram_wmask, 32'd0);
        chk("idle_din", sram_din, 32'd0);
        rd_check("bit7", 15'd7, 32'd0);
        rd_check("bit6", 15'd6, 32'd1);

        // cfg request beats a same-cycle request and waits for the in-flight read
        set_conf(3'd0);
        bus.rsp_ready = 1'b0;
        do_req(1'b0, 15'd5, '0);
        cfg_valid = 1'b1;
        cfg_conf  = 3'd2;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 15'd0;
        bus.req_wdata = 32'hFFFF_FFFF;
        #1;
        chk("cfg_req_refused", 32'(bus.req_ready), 32'd0);
        step();
        chk("cfg_no_access", 32'(sram_en), 32'd0);
        chk("cfg_wait_drain", 32'(cfg_ready), 32'd0);
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            if (cfg_ready) got = 1'b1;
            step();
        end
        cfg_valid = 1'b0;
        bus.req_valid = 1'b0;
        chk("cfg_drained_ready", 32'(got), 32'd1);
        chk("cfg_new_conf", 32'(conf), 32'd2);
        wait_rsp(d, lat);
        chk("cfg_old_read", d, 32'hBEEF_1234);
        do_req(1'b0, 15'h0013, '0);
        chk("cfg_new_addr", 32'(sram_addr), 32'd4);
        wait_rsp(d, lat);
        chk("cfg_new_read", d, 32'h0000_00CD);
        cur_conf = 3'd2;

        // Response backpressure: reads bounded by FIFO credits, writes unaffected
        set_conf(3'd0);
        do_req(1'b1, 15'd10, 32'h1111_000A);
        do_req(1'b1, 15'd11, 32'h2222_000B);
        bus.rsp_ready = 1'b0;
        acc = 0;
        for (int n = 0; n < 8; n++) begin
            bus.req_valid = 1'b1;
            bus.req_we    = 1'b0;
            bus.req_addr  = 15'(10 + acc);
            #1;
            rdy = bus.req_ready;
            step();
            if (rdy) acc++;
        end
        chk("reads_accepted", 32'(acc), 32'd2);
        #1;
        chk("full_read_blocked", 32'(bus.req_ready), 32'd0);
        bus.req_we    = 1'b1;
        bus.req_addr  = 15'd20;
        bus.req_wdata = 32'h5555_5555;
        #1;
        chk("full_write_ready", 32'(bus.req_ready), 32'd1);
        step();
        bus.req_valid = 1'b0;
        chk("full_write_issued", 32'(sram_we), 32'd1);
        chk("stalled_rsp_data", bus.rsp_data, 32'h1111_000A);
        bus.rsp_ready = 1'b1;
        nr = 0;
        for (int n = 0; n < 10; n++) begin
            if (bus.rsp_valid) begin
                if (nr < 4) got_d[nr] = bus.rsp_data;
                nr++;
            end
            step();
        end
        chk("drain_count", 32'(nr), 32'd2);
        chk("drain_first", got_d[0], 32'h1111_000A);
        chk("drain_second", got_d[1], 32'h2222_000B);
        chk("drain_busy", 32'(busy), 32'd0);
        rd_check("write_while_full", 15'd20, 32'h5555_5555);

        // Reset one cycle after a read is issued
        set_conf(3'd2);
        do_req(1'b0, 15'h0013, '0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        nr = 0;
        for (int n = 0; n < 6; n++) begin
            if (bus.rsp_valid) nr++;
            step();
        end
        chk("rst_mid_read_rsp", 32'(nr), 32'd0);
        chk("rst_mid_read_conf", 32'(conf), 32'd0);
        chk("rst_mid_read_busy", 32'(busy), 32'd0);
        chk("rst_mid_read_en", 32'(sram_en), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
